// File: rtl/dtree_pkg.sv
// dtree_pkg: default widths, accumulator sizing and state encoding
// shared by the decision-tree node datapath.
package dtree_pkg;

   localparam int FEATURES          = 3;
   localparam int FEATURE_BIT_DEPTH = 10;
   localparam int COEFF_BIT_DEPTH   = 4;
   localparam int BIAS_BIT_DEPTH    = 10;

   function automatic int acc_width(input int nf, input int fw, input int cw);
      return fw + cw + $clog2(nf) + 2;
   endfunction

   localparam int ACC_BIT_DEPTH =
      acc_width(FEATURES, FEATURE_BIT_DEPTH, COEFF_BIT_DEPTH);

   typedef enum logic {
      LOAD = 1'b0,
      EVAL = 1'b1
   } state_e;

endpackage

// File: rtl/feature_buffer.sv
// feature_buffer: holds one spike's feature samples and steps the term index.
// Define NODE_EVAL_DBUF_EN for a ping-pong pair that loads while evaluating.
module feature_buffer #(
   parameter int NF = dtree_pkg::FEATURES,
   parameter int FW = dtree_pkg::FEATURE_BIT_DEPTH,
   parameter int KW = $clog2(NF + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_s_valid,
   input  logic [FW-1:0] i_s_data,
   input  logic          i_node_go,
   input  logic          i_release,
   output logic          o_s_ready,
   output logic          o_busy,
   output logic          o_drain,
   output logic [FW-1:0] o_feat
);
   import dtree_pkg::*;

   state_e        r_state;
   state_e        w_state_nxt;
   logic [FW-1:0] r_mem [2][NF];
   logic [KW-1:0] r_wptr;
   logic [KW-1:0] r_k;
   logic          w_wr;
   logic          w_last;
   logic          w_wbank;
   logic          w_rbank;
   logic          w_idle_full;
   logic          w_wclr;

   assign w_wr    = i_s_valid & o_s_ready;
   assign w_last  = w_wr & (r_wptr == KW'(NF - 1));
   assign o_drain = (r_k == KW'(NF));

`ifdef NODE_EVAL_DBUF_EN
   logic r_act;
   logic r_idle_full;

   // While evaluating, new samples land in the idle bank.
   assign w_wbank     = (r_state == EVAL) ? ~r_act : r_act;
   assign w_rbank     = r_act;
   assign w_idle_full = r_idle_full | (w_last & (r_state == EVAL));
   assign w_wclr      = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_act       <= 1'b0;
         r_idle_full <= 1'b0;
      end else if (i_release) begin
         r_act       <= ~r_act;
         r_idle_full <= 1'b0;
      end else if (w_last & (r_state == EVAL)) begin
         r_idle_full <= 1'b1;
      end
   end
`else
   assign w_wbank     = 1'b0;
   assign w_rbank     = 1'b0;
   assign w_idle_full = 1'b0;
   assign w_wclr      = i_release;
`endif

   always_ff @(posedge clk) begin
      if (reset) r_state <= LOAD;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         LOAD: if (w_last) w_state_nxt = EVAL;
         EVAL: if (i_release) w_state_nxt = w_idle_full ? EVAL : LOAD;
      endcase
   end

   always_comb begin
      o_s_ready = 1'b0;
      o_busy    = (r_state == EVAL);
      if (!reset) begin
`ifdef NODE_EVAL_DBUF_EN
         o_s_ready = (r_state == LOAD) | ~r_idle_full;
`else
         o_s_ready = (r_state == LOAD);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_wclr) r_wptr <= '0;
      else if (w_wr)       r_wptr <= w_last ? '0 : r_wptr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[w_wbank][r_wptr] <= i_s_data;
   end

   always_ff @(posedge clk) begin
      if (reset || i_release) r_k <= '0;
      else if (i_node_go)     r_k <= o_drain ? '0 : r_k + 1'b1;
   end

   always_comb begin
      o_feat = '0;
      for (int i = 0; i < NF; i++) begin
         if (r_k == KW'(i)) o_feat = r_mem[w_rbank][i];
      end
   end

endmodule

// File: rtl/node_evaluator.sv
// node_evaluator: bias + sum(coeff*feature) for one tree node, sign -> branch.
// Build with NODE_EVAL_DBUF_EN for the ping-pong feature buffer.
module node_evaluator #(
   parameter int FEATURES          = dtree_pkg::FEATURES,
   parameter int FEATURE_BIT_DEPTH = dtree_pkg::FEATURE_BIT_DEPTH,
   parameter int COEFF_BIT_DEPTH   = dtree_pkg::COEFF_BIT_DEPTH,
   parameter int BIAS_BIT_DEPTH    = dtree_pkg::BIAS_BIT_DEPTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         s_valid,
   input  logic [FEATURE_BIT_DEPTH-1:0] s_data,
   output logic                         s_ready,
   input  logic                         node_valid,
   input  logic                         load_bias,
   input  logic                         add,
   input  logic                         mult,
   input  logic                         is_one,
   input  logic                         is_zero,
   input  logic [COEFF_BIT_DEPTH-1:0]   coeff,
   input  logic [BIAS_BIT_DEPTH-1:0]    bias,
   input  logic                         out_valid,
   output logic                         child_direction,
   output logic                         dir_valid,
   output logic                         busy,
   output logic                         protocol_err
);
   import dtree_pkg::*;

   localparam int FW = FEATURE_BIT_DEPTH;
   localparam int CW = COEFF_BIT_DEPTH;
   localparam int BW = BIAS_BIT_DEPTH;
   localparam int AW = acc_width(FEATURES, FW, CW);
   localparam int PW = FW + CW;

   logic                 w_busy;
   logic                 w_drain;
   logic                 w_node_go;
   logic                 w_release;
   logic                 w_mult;
   logic [FW-1:0]        w_feat;
   logic signed [PW-1:0] w_fx;
   logic signed [PW-1:0] w_cx;
   logic signed [PW-1:0] w_prod;
   logic signed [AW-1:0] w_term;
   logic signed [AW-1:0] w_pend;
   logic signed [AW-1:0] w_bias;
   logic signed [AW-1:0] w_acc_nxt;
   logic signed [AW-1:0] r_acc;
   logic signed [PW-1:0] r_prod;
   logic                 r_pend;
   logic                 r_dir;
   logic                 r_dir_valid;
   logic                 r_err;

   feature_buffer #(
      .NF (FEATURES),
      .FW (FW)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .i_s_valid (s_valid),
      .i_s_data  (s_data),
      .i_node_go (w_node_go),
      .i_release (w_release),
      .o_s_ready (s_ready),
      .o_busy    (w_busy),
      .o_drain   (w_drain),
      .o_feat    (w_feat)
   );

   // Release wins over a coincident node cycle.
   assign w_release = out_valid & w_busy;
   assign w_node_go = node_valid & w_busy & ~out_valid;

   assign w_mult = mult & ~is_one & ~is_zero & ~w_drain;
   assign w_fx   = {{CW{w_feat[FW-1]}}, w_feat};
   assign w_cx   = {{FW{coeff[CW-1]}}, coeff};
   assign w_prod = w_fx * w_cx;
   assign w_bias = {{(AW-BW){bias[BW-1]}}, bias};

   always_comb begin
      w_term = '0;
      if (is_one & ~is_zero & ~w_drain)
         w_term = {{(AW-FW){w_feat[FW-1]}}, w_feat};
      w_pend = '0;
      if (r_pend)
         w_pend = {{(AW-PW){r_prod[PW-1]}}, r_prod};
      w_acc_nxt = r_acc;
      if (load_bias)
         w_acc_nxt = w_bias + w_term + w_pend;
      else if (add)
         w_acc_nxt = r_acc + w_term + w_pend;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc       <= '0;
         r_prod      <= '0;
         r_pend      <= 1'b0;
         r_dir       <= 1'b0;
         r_dir_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_dir_valid <= w_node_go & w_drain;
         if (w_node_go & w_drain)
            r_dir <= ~w_acc_nxt[AW-1];
         if (w_release) begin
            r_pend <= 1'b0;
         end else if (w_node_go) begin
            r_acc  <= w_acc_nxt;
            r_pend <= w_mult;
            if (w_mult) r_prod <= w_prod;
         end
         if (node_valid & ~w_busy)
            r_err <= 1'b1;
      end
   end

   assign child_direction = r_dir;
   assign dir_valid       = r_dir_valid;
   assign busy            = w_busy;
   assign protocol_err    = r_err;

endmodule

// File: tb/tb_node_evaluator.sv
// tb_node_evaluator: directed bursts against a queue of expected directions.
// Covers loading, mult/is_one/is_zero terms, release, protocol error, reset.
module tb_node_evaluator;

   logic       clk = 1'b0;
   logic       reset;
   logic       s_valid;
   logic [9:0] s_data;
   logic       s_ready;
   logic       node_valid;
   logic       load_bias;
   logic       add;
   logic       mult;
   logic       is_one;
   logic       is_zero;
   logic [3:0] coeff;
   logic [9:0] bias;
   logic       out_valid;
   logic       child_direction;
   logic       dir_valid;
   logic       busy;
   logic       protocol_err;

   int total = 0;
   int bad   = 0;
   int n_dir = 0;
   int d0;
   bit exp_q[$];

   always #5 clk = ~clk;

   node_evaluator dut (
      .clk             (clk),
      .reset           (reset),
      .s_valid         (s_valid),
      .s_data          (s_data),
      .s_ready         (s_ready),
      .node_valid      (node_valid),
      .load_bias       (load_bias),
      .add             (add),
      .mult            (mult),
      .is_one          (is_one),
      .is_zero         (is_zero),
      .coeff           (coeff),
      .bias            (bias),
      .out_valid       (out_valid),
      .child_direction (child_direction),
      .dir_valid       (dir_valid),
      .busy            (busy),
      .protocol_err    (protocol_err)
   );

   always @(negedge clk) if (dir_valid === 1'b1) n_dir++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      node_valid = 0; load_bias = 0; add = 0; mult = 0;
      is_one = 0; is_zero = 0; coeff = '0; bias = '0;
   endtask

   task automatic load(input logic [9:0] v);
      chk("s_ready_load", 32'(s_ready), 1);
      s_valid = 1; s_data = v;
      cyc();
      s_valid = 0;
   endtask

   task automatic step(input bit lb, input bit ad, input bit ml,
                       input bit one, input bit zero,
                       input logic [3:0] c, input logic [9:0] b);
      node_valid = 1; load_bias = lb; add = ad; mult = ml;
      is_one = one; is_zero = zero; coeff = c; bias = b;
      cyc();
      clr();
   endtask

   task automatic drain(input bit e);
      exp_q.push_back(e);
      node_valid = 1; add = 1;
      cyc();
      clr();
      if (dir_valid === 1'b1) begin
         chk("child_direction", 32'(child_direction), 32'(exp_q.pop_front()));
      end else begin
         chk("dir_valid_pulse", 32'(dir_valid), 1);
         exp_q.delete();
      end
      cyc();
      chk("dir_valid_one_cycle", 32'(dir_valid), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1; s_valid = 0; s_data = '0; out_valid = 0;
      clr();
      cyc();
      cyc();
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_dir_valid", 32'(dir_valid), 0);
      chk("rst_child", 32'(child_direction), 0);
      chk("rst_err", 32'(protocol_err), 0);
      reset = 0;
      cyc();
      chk("post_rst_s_ready", 32'(s_ready), 1);

      // -10 + 5 + 2*(-3) = -11
      load(10'sd5); load(-10'sd3); load(10'sd7);
      chk("full_busy", 32'(busy), 1);
      chk("full_s_ready", 32'(s_ready), 0);
      step(1, 0, 0, 1, 0, 4'sd0, -10'sd10);
      step(0, 0, 1, 0, 0, 4'sd2, 10'sd0);
      step(0, 1, 0, 0, 1, 4'sd0, 10'sd0);
      drain(1'b0);

      // sample offered while not ready is dropped silently
      s_valid = 1; s_data = 10'sd100;
      cyc();
      s_valid = 0;
      chk("drop_s_ready", 32'(s_ready), 0);
      chk("drop_err", 32'(protocol_err), 0);

      // 4 + 5 + 3 - 14 = -2, then 7 + 5 + 3 - 14 = 1
      step(1, 0, 0, 1, 0, 4'sd0, 10'sd4);
      step(0, 0, 1, 0, 0, -4'sd1, 10'sd0);
      step(0, 1, 1, 0, 0, -4'sd2, 10'sd0);
      drain(1'b0);
      chk("between_s_ready", 32'(s_ready), 0);
      step(1, 0, 0, 1, 0, 4'sd0, 10'sd7);
      step(0, 0, 1, 0, 0, -4'sd1, 10'sd0);
      step(0, 1, 1, 0, 0, -4'sd2, 10'sd0);
      drain(1'b1);
      chk("pulses_after_levels", 32'(n_dir), 3);

      // release collides with a node cycle
      d0 = n_dir;
      out_valid = 1; node_valid = 1; load_bias = 1; bias = 10'sd100;
      cyc();
      out_valid = 0;
      clr();
      chk("release_s_ready", 32'(s_ready), 1);
      chk("release_busy", 32'(busy), 0);
      chk("release_err", 32'(protocol_err), 0);
      cyc();
      cyc();
      chk("release_no_dir", 32'(n_dir), 32'(d0));

      // node cycles on a partial buffer: flagged, acc untouched (stays 1)
      load(10'sd1); load(10'sd2);
      chk("partial_busy", 32'(busy), 0);
      step(1, 0, 0, 1, 0, 4'sd0, 10'sd100);
      chk("proto_err_set", 32'(protocol_err), 1);
      step(0, 1, 0, 1, 0, 4'sd0, 10'sd0);
      step(0, 1, 0, 0, 0, 4'sd0, 10'sd0);
      step(0, 1, 0, 0, 0, 4'sd0, 10'sd0);
      cyc();
      chk("proto_no_dir", 32'(n_dir), 32'(d0));
      load(-10'sd5);
      chk("proto_busy", 32'(busy), 1);
      step(0, 1, 0, 0, 0, 4'sd0, 10'sd0);
      step(0, 1, 0, 0, 0, 4'sd0, 10'sd0);
      step(0, 1, 0, 1, 0, 4'sd0, 10'sd0);
      drain(1'b0);
      chk("proto_err_sticky", 32'(protocol_err), 1);

      // reset in mid-burst after a positive decision
      out_valid = 1;
      cyc();
      out_valid = 0;
      load(10'sd5); load(-10'sd3); load(10'sd7);
      step(1, 0, 0, 1, 0, 4'sd0, 10'sd7);
      step(0, 0, 1, 0, 0, -4'sd1, 10'sd0);
      step(0, 1, 1, 0, 0, -4'sd2, 10'sd0);
      drain(1'b1);
      step(1, 0, 0, 1, 0, 4'sd0, 10'sd7);
      node_valid = 1; mult = 1; coeff = -4'sd1; reset = 1;
      cyc();
      clr();
      chk("midrst_s_ready", 32'(s_ready), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_dir_valid", 32'(dir_valid), 0);
      chk("midrst_child", 32'(child_direction), 0);
      chk("midrst_err", 32'(protocol_err), 0);
      reset = 0;
      cyc();
      chk("midrst_ready_after", 32'(s_ready), 1);

      // -3 + 2 + 1*4 + (-1) = 2
      load(10'sd2); load(10'sd4); load(-10'sd1);
      step(1, 0, 0, 1, 0, 4'sd0, -10'sd3);
      step(0, 0, 1, 0, 0, 4'sd1, 10'sd0);
      step(0, 1, 0, 1, 0, 4'sd0, 10'sd0);
      drain(1'b1);
      chk("queue_empty", 32'(exp_q.size()), 0);
      chk("total_pulses", 32'(n_dir), 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
